// File: rtl/pbch_ram_if.sv
// Bundle between the PBCH sample-RAM sequencer, the FFT writer, the downstream
// reader and the single-port RAM macro.
interface pbch_ram_if #(
    parameter int RAM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                         sym_start;
    logic                         wr_valid;
    logic signed [RAM_WIDTH-1:0]  wr_data;
    logic                         wr_ready;
    logic                         rd_req;
    logic        [ADDR_WIDTH-1:0] rd_addr;
    logic                         rd_ready;
    logic                         rd_release;
    logic                         rd_valid;
    logic signed [RAM_WIDTH-1:0]  rd_data;
    logic                         rd_err;
    logic                         buf_full;
    logic        [ADDR_WIDTH-1:0] ram_addr;
    logic signed [RAM_WIDTH-1:0]  ram_din;
    logic                         ram_wre;
    logic signed [RAM_WIDTH-1:0]  ram_dout;

    // Controller side.
    modport slave (
        input  sym_start, wr_valid, wr_data, rd_req, rd_addr, rd_release, ram_dout,
        output wr_ready, rd_ready, rd_valid, rd_data, rd_err, buf_full,
               ram_addr, ram_din, ram_wre
    );

    // Environment side: FFT writer, consumer and RAM.
    modport master (
        output sym_start, wr_valid, wr_data, rd_req, rd_addr, rd_release, ram_dout,
        input  wr_ready, rd_ready, rd_valid, rd_data, rd_err, buf_full,
               ram_addr, ram_din, ram_wre
    );
endinterface

// File: rtl/pbch_ram_ctrl.sv
// Sequencer for the single-port post-FFT sample RAM: sequential fill from the
// FFT stream, then random-address reads by the consumer until it releases the buffer.
module pbch_ram_ctrl #(
    parameter int RAM_WIDTH  = 32,
    parameter int RAM_DEPTH  = 240,
    parameter int ADDR_WIDTH = 10
) (
    input  logic      clk,
    input  logic      rst,
    pbch_ram_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic                  wr_hs;
    logic                  rd_hs;
    logic                  rd_in_range;
    logic                  vld_p1;
    logic                  err_p1;
    logic                  full_q;

    // Stage 0: handshakes and RAM port drive, combinational from state and inputs
    always_comb begin
        wr_hs       = bus.wr_valid && (state == FILL);
        rd_hs       = bus.rd_req && (state == READ);
        rd_in_range = {1'b0, bus.rd_addr} < DEPTH_EXT;

        bus.wr_ready = (state == FILL);
        bus.rd_ready = (state == READ);
        bus.ram_wre  = wr_hs;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (wr_hs) begin
            bus.ram_addr = wr_cnt;
            bus.ram_din  = bus.wr_data;
        end else if (rd_hs && rd_in_range) begin
            // Out-of-range reads park the address at 0 and are flagged instead.
            bus.ram_addr = bus.rd_addr;
        end
    end

    // Stage 1: read response, aligned with the RAM's registered dout
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            wr_cnt <= '0;
            full_q <= 1'b0;
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_hs;
            err_p1 <= rd_hs && !rd_in_range;
            case (state)
                IDLE: begin
                    if (bus.sym_start) begin
                        state  <= FILL;
                        wr_cnt <= '0;
                    end
                end
                FILL: begin
                    // A restart discards the partial symbol; a write in the same
                    // cycle still lands at the old count but is not counted.
                    if (bus.sym_start) begin
                        wr_cnt <= '0;
                    end else if (wr_hs) begin
                        if (wr_cnt == LAST_ADDR) begin
                            state  <= READ;
                            wr_cnt <= '0;
                            full_q <= 1'b1;
                        end else begin
                            wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                READ: begin
                    if (bus.rd_release) begin
                        state  <= IDLE;
                        full_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wr_cnt <= '0;
                    full_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_valid = vld_p1;
    assign bus.rd_err   = err_p1;
    assign bus.buf_full = full_q;
    assign bus.rd_data  = (vld_p1 && !err_p1) ? bus.ram_dout : '0;
endmodule

// File: tb/tb_pbch_ram_ctrl.sv
// Self-checking bench for pbch_ram_ctrl with a behavioural single-port RAM
// and a read-response scoreboard.
module tb_pbch_ram_ctrl;
    localparam int RW = 32;
    localparam int RD = 240;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pbch_ram_if #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    pbch_ram_ctrl #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, 1-cycle latency, read-before-write.
    logic signed [RW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_wre) ram[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= ram[bus.ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;
    logic signed [RW-1:0] exp_mem [0:RD-1];
    logic signed [RW-1:0] q_data[$];
    bit                   q_err[$];
    int                   rd_list[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sym_start  = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;
    endtask

    task automatic start_symbol();
        bus.sym_start = 1'b1;
        tick();
        bus.sym_start = 1'b0;
        #2;
        n_vec++;
        if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL start_fill wr_ready=%b rd_ready=%b want 1/0", bus.wr_ready, bus.rd_ready);
        end
    endtask

    task automatic write_stream(input int n, input logic signed [RW-1:0] base, input bit gap);
        logic signed [RW-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                bus.wr_valid = 1'b0;
                #2;
                n_vec++;
                if (bus.ram_wre !== 1'b0 || bus.ram_addr !== '0 || bus.wr_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall i=%0d wre=%b addr=%0d wr_ready=%b want 0/0/1",
                             i, bus.ram_wre, bus.ram_addr, bus.wr_ready);
                end
                tick();
            end
            d = base + RW'(i);
            bus.wr_valid = 1'b1;
            bus.wr_data  = d;
            #2;
            n_vec++;
            if (bus.ram_wre !== 1'b1 || bus.ram_addr !== AW'(i) || bus.ram_din !== d) begin
                n_err++;
                $display("FAIL write i=%0d wre=%b addr=%0d din=%0d want 1/%0d/%0d",
                         i, bus.ram_wre, bus.ram_addr, bus.ram_din, i, d);
            end
            n_vec++;
            if (bus.buf_full !== 1'b0 || bus.wr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL fill_flags i=%0d buf_full=%b wr_ready=%b want 0/1", i, bus.buf_full, bus.wr_ready);
            end
            exp_mem[i] = d;
            tick();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic check_full();
        n_vec++;
        if (bus.buf_full !== 1'b1 || bus.rd_ready !== 1'b1 || bus.wr_ready !== 1'b0 || bus.ram_wre !== 1'b0) begin
            n_err++;
            $display("FAIL full buf_full=%b rd_ready=%b wr_ready=%b wre=%b want 1/1/0/0",
                     bus.buf_full, bus.rd_ready, bus.wr_ready, bus.ram_wre);
        end
    endtask

    task automatic read_list();
        logic signed [RW-1:0] d;
        bit e;
        int ea;
        foreach (rd_list[k]) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = AW'(rd_list[k]);
            ea = (rd_list[k] < RD) ? rd_list[k] : 0;
            #2;
            n_vec++;
            if (bus.rd_ready !== 1'b1 || bus.ram_wre !== 1'b0 || bus.ram_addr !== AW'(ea)) begin
                n_err++;
                $display("FAIL rd_issue a=%0d rd_ready=%b wre=%b addr=%0d want 1/0/%0d",
                         rd_list[k], bus.rd_ready, bus.ram_wre, bus.ram_addr, ea);
            end
            q_data.push_back((rd_list[k] < RD) ? exp_mem[rd_list[k]] : '0);
            q_err.push_back(rd_list[k] >= RD);
            tick();
            n_vec++;
            if (bus.rd_valid !== 1'b1 || q_data.size() == 0) begin
                n_err++;
                $display("FAIL rd_valid a=%0d rd_valid=%b want 1", rd_list[k], bus.rd_valid);
                q_data.delete();
                q_err.delete();
            end else begin
                d = q_data.pop_front();
                e = q_err.pop_front();
                if (bus.rd_data !== d || bus.rd_err !== e) begin
                    n_err++;
                    $display("FAIL rd_data a=%0d data=%0d err=%b want %0d/%b",
                             rd_list[k], bus.rd_data, bus.rd_err, d, e);
                end
            end
        end
        bus.rd_req = 1'b0;
        tick();
        n_vec++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0 || bus.rd_err !== 1'b0) begin
            n_err++;
            $display("FAIL rd_idle rd_valid=%b data=%0d err=%b want 0/0/0", bus.rd_valid, bus.rd_data, bus.rd_err);
        end
    endtask

    task automatic release_buf();
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        n_vec++;
        if (bus.buf_full !== 1'b0 || bus.rd_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL release buf_full=%b rd_ready=%b wr_ready=%b want 0/0/0",
                     bus.buf_full, bus.rd_ready, bus.wr_ready);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0 || bus.rd_valid !== 1'b0 ||
            bus.rd_err !== 1'b0 || bus.buf_full !== 1'b0 || bus.ram_wre !== 1'b0 ||
            bus.ram_addr !== '0 || bus.ram_din !== '0 || bus.rd_data !== '0) begin
            n_err++;
            $display("FAIL %s wr_rdy=%b rd_rdy=%b rd_vld=%b err=%b full=%b wre=%b addr=%0d din=%0d data=%0d want all 0",
                     tag, bus.wr_ready, bus.rd_ready, bus.rd_valid, bus.rd_err, bus.buf_full,
                     bus.ram_wre, bus.ram_addr, bus.ram_din, bus.rd_data);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset_values");
        rst = 1'b1;
        tick();
        n_vec++;
        if (bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold wr_ready=%b rd_ready=%b want 0/0", bus.wr_ready, bus.rd_ready);
        end
    endtask

    task automatic test_fill();
        start_symbol();
        write_stream(RD, 0, 1'b0);
        check_full();
    endtask

    task automatic test_read_b2b();
        rd_list.delete();
        rd_list.push_back(17);
        rd_list.push_back(0);
        rd_list.push_back(239);
        read_list();
    endtask

    task automatic test_sym_start_in_read();
        bus.sym_start = 1'b1;
        tick();
        bus.sym_start = 1'b0;
        tick();
        check_full();
    endtask

    task automatic test_release_with_read();
        logic signed [RW-1:0] d;
        bus.rd_req     = 1'b1;
        bus.rd_addr    = AW'(5);
        bus.rd_release = 1'b1;
        bus.sym_start  = 1'b1;
        q_data.push_back(exp_mem[5]);
        q_err.push_back(1'b0);
        tick();
        idle_inputs();
        d = q_data.pop_front();
        void'(q_err.pop_front());
        n_vec++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== d || bus.rd_err !== 1'b0) begin
            n_err++;
            $display("FAIL release_read rd_valid=%b data=%0d err=%b want 1/%0d/0",
                     bus.rd_valid, bus.rd_data, bus.rd_err, d);
        end
        n_vec++;
        if (bus.buf_full !== 1'b0 || bus.rd_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL release_state buf_full=%b rd_ready=%b wr_ready=%b want 0/0/0",
                     bus.buf_full, bus.rd_ready, bus.wr_ready);
        end
        tick();
        n_vec++;
        if (bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sym_start_dropped wr_ready=%b rd_valid=%b want 0/0", bus.wr_ready, bus.rd_valid);
        end
    endtask

    task automatic test_gap_fill();
        start_symbol();
        write_stream(RD, -1000, 1'b1);
        check_full();
        rd_list.delete();
        rd_list.push_back(0);
        rd_list.push_back(120);
        rd_list.push_back(239);
        read_list();
    endtask

    task automatic test_out_of_range();
        rd_list.delete();
        rd_list.push_back(240);
        rd_list.push_back(1023);
        rd_list.push_back(3);
        read_list();
        release_buf();
    endtask

    task automatic test_restart();
        start_symbol();
        write_stream(100, 1000, 1'b0);
        bus.sym_start = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 7777;
        #2;
        n_vec++;
        if (bus.ram_wre !== 1'b1 || bus.ram_addr !== AW'(100) || bus.ram_din !== 7777) begin
            n_err++;
            $display("FAIL restart_write wre=%b addr=%0d din=%0d want 1/100/7777",
                     bus.ram_wre, bus.ram_addr, bus.ram_din);
        end
        tick();
        bus.sym_start = 1'b0;
        bus.wr_valid  = 1'b0;
        write_stream(RD, -77, 1'b0);
        check_full();
        rd_list.delete();
        for (int a = 0; a < RD; a++) rd_list.push_back(a);
        read_list();
        release_buf();
    endtask

    task automatic test_reset_mid();
        start_symbol();
        write_stream(50, 0, 1'b0);
        rst = 1'b0;
        tick();
        check_reset_outputs("reset_in_fill");
        rst = 1'b1;
        tick();
        check_reset_outputs("idle_after_reset");
        start_symbol();
        write_stream(RD, 300, 1'b0);
        check_full();
        bus.rd_req  = 1'b1;
        bus.rd_addr = AW'(9);
        rst = 1'b0;
        tick();
        bus.rd_req = 1'b0;
        check_reset_outputs("reset_in_read");
        rst = 1'b1;
        tick();
        check_reset_outputs("idle_after_read_reset");
    endtask

    initial begin
        idle_inputs();
        bus.ram_dout = '0;
        test_reset();
        test_fill();
        test_read_b2b();
        test_sym_start_in_read();
        test_release_with_read();
        test_gap_fill();
        test_out_of_range();
        test_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
